// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory, little-endian,
// holding the core off the memory until the program is loaded or the memory is full.
module imem_loader #(
  parameter int unsigned DEPTH_BYTES = 32,
  parameter int unsigned ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_word,
  input  logic              in_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              trunc_err,
  output logic [ADDR_W-2:0] word_count
);

  localparam int unsigned WcW = ADDR_W - 1;
  localparam logic [WcW-1:0] MaxWords = WcW'(DEPTH_BYTES / 4);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [WcW-1:0]    word_count_q, word_count_d;
  logic              trunc_q, trunc_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic [7:0]        data_hold_q, data_hold_d;

  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        cur_data;
  logic [WcW-1:0]    wc_inc;

  // word_count < DEPTH_BYTES/4 while writing, so its low bits form the word address.
  assign cur_addr = {word_count_q[WcW-2:0], idx_q};
  assign cur_data = word_q[8*idx_q +: 8];
  assign wc_inc   = word_count_q + WcW'(1);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    word_count_d = word_count_q;
    trunc_d      = trunc_q;
    word_d       = word_q;
    last_d       = last_q;
    addr_hold_d  = addr_hold_q;
    data_hold_d  = data_hold_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          word_d  = in_word;
          last_d  = in_last;
          idx_d   = 2'd0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        addr_hold_d = cur_addr;
        data_hold_d = cur_data;
        idx_d       = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          word_count_d = wc_inc;
          if (last_q || (wc_inc == MaxWords)) begin
            state_d = StDone;
            if (!last_q) trunc_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= 2'd0;
      word_count_q <= '0;
      trunc_q      <= 1'b0;
      word_q       <= 32'd0;
      last_q       <= 1'b0;
      addr_hold_q  <= '0;
      data_hold_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      word_count_q <= word_count_d;
      trunc_q      <= trunc_d;
      word_q       <= word_d;
      last_q       <= last_d;
      addr_hold_q  <= addr_hold_d;
      data_hold_q  <= data_hold_d;
    end
  end

  // Address/data hold their last written values while idle for readable waveforms.
  assign in_ready   = (state_q == StIdle);
  assign wr_en      = (state_q == StWrite);
  assign wr_addr    = wr_en ? cur_addr : addr_hold_q;
  assign wr_data    = wr_en ? cur_data : data_hold_q;
  assign cpu_hold   = (state_q != StDone);
  assign load_done  = (state_q == StDone);
  assign trunc_err  = trunc_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with hand-computed expectations.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        in_last;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        cpu_hold;
  logic        load_done;
  logic        trunc_err;
  logic [3:0]  word_count;

  int n_cmp;
  int n_err;

  imem_loader #(
    .DEPTH_BYTES(32),
    .ADDR_W     (5)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_last   (in_last),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .trunc_err (trunc_err),
    .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Offers one word in IDLE, scrambles inputs during WRITE, checks the four byte writes.
  task automatic send_word(input logic [31:0] w, input logic l, input int base);
    logic [7:0] b;
    in_word  = w;
    in_last  = l;
    in_valid = 1'b1;
    check("accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_word = ~w;
    in_last = ~l;
    for (int i = 0; i < 4; i++) begin
      b = w[8*i +: 8];
      check("byte_wr_en", 32'(wr_en), 32'd1);
      check("byte_addr", 32'(wr_addr), 32'(base + i));
      check("byte_data", 32'(wr_data), 32'(b));
      tick();
    end
  endtask

  logic [7:0] exp_b [4];

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    in_word  = 32'd0;
    in_last  = 1'b0;
    in_valid = 1'b0;
    reset    = 1'b1;

    // Reset state.
    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_trunc", 32'(trunc_err), 32'd0);
    tick();
    check("idle_wr_en", 32'(wr_en), 32'd0);

    // Single word 0x00940333 with in_last.
    exp_b[0] = 8'h33; exp_b[1] = 8'h03; exp_b[2] = 8'h94; exp_b[3] = 8'h00;
    in_word  = 32'h0094_0333;
    in_last  = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("one_wr_en", 32'(wr_en), 32'd1);
      check("one_addr", 32'(wr_addr), 32'(i));
      check("one_data", 32'(wr_data), 32'(exp_b[i]));
      check("one_not_done", 32'(load_done), 32'd0);
      tick();
    end
    check("one_done", 32'(load_done), 32'd1);
    check("one_cpu_hold", 32'(cpu_hold), 32'd0);
    check("one_word_count", 32'(word_count), 32'd1);
    check("one_trunc", 32'(trunc_err), 32'd0);
    check("one_wr_en_off", 32'(wr_en), 32'd0);
    check("one_hold_addr", 32'(wr_addr), 32'd3);
    check("one_in_ready", 32'(in_ready), 32'd0);

    // Eight words back to back, in_last on the eighth: 40 cycles.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      send_word(32'hA0B0_C0D0 ^ (32'(k) * 32'h0101_0101), (k == 7), 4 * k);
      if (k == 7) check("full8_done_at_40", 32'(load_done), 32'd1);
      else        check("full8_not_done", 32'(load_done), 32'd0);
    end
    in_valid = 1'b0;
    check("full8_word_count", 32'(word_count), 32'd8);
    check("full8_trunc", 32'(trunc_err), 32'd0);

    // Eight words without in_last: truncation, ninth offer ignored.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      send_word(32'h1357_9BDF + 32'(k), 1'b0, 4 * k);
    end
    check("trunc_done", 32'(load_done), 32'd1);
    check("trunc_err", 32'(trunc_err), 32'd1);
    in_word  = 32'hDEAD_BEEF;
    in_last  = 1'b1;
    in_valid = 1'b1;
    check("ninth_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ninth_no_wr", 32'(wr_en), 32'd0);
    end
    check("ninth_word_count", 32'(word_count), 32'd8);
    check("trunc_sticky", 32'(trunc_err), 32'd1);
    in_valid = 1'b0;

    // Reset beats a simultaneous handshake.
    reset    = 1'b1;
    in_valid = 1'b1;
    in_word  = 32'h1111_1111;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    check("rstprio_trunc_clr", 32'(trunc_err), 32'd0);
    check("rstprio_wr_en", 32'(wr_en), 32'd0);
    tick();
    check("rstprio_no_accept", 32'(wr_en), 32'd0);
    check("rstprio_ready", 32'(in_ready), 32'd1);

    // Reset while writing byte 2 of word 3, then restart at address 0.
    do_reset();
    for (int k = 0; k < 3; k++) send_word(32'h0102_0304 + 32'(k << 24), 1'b0, 4 * k);
    in_word  = 32'hCAFE_F00D;
    in_last  = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mid_wr_en", 32'(wr_en), 32'd1);
    check("mid_addr", 32'(wr_addr), 32'd14);
    check("mid_data", 32'(wr_data), 32'hFE);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_wr_en", 32'(wr_en), 32'd0);
    check("abort_word_count", 32'(word_count), 32'd0);
    tick();
    check("abort_still_idle", 32'(wr_en), 32'd0);
    send_word(32'h7654_3210, 1'b1, 0);
    in_valid = 1'b0;
    check("restart_done", 32'(load_done), 32'd1);
    check("restart_word_count", 32'(word_count), 32'd1);
    check("restart_trunc", 32'(trunc_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
